// File: rtl/nano_riscv_mc.sv
// rtl/nano_riscv_mc.sv - multi-cycle RV32I/RV32E core with req/ack fetch and data ports
// FETCH -> EXEC -> (MEM) -> FETCH; faults park the core in HALT with a sticky cause.
module nano_riscv_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_wstrb,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_retire,
  output logic [31:0] o_retire_pc,
  output logic [31:0] o_debug,
  output logic        o_halt,
  output logic [2:0]  o_cause
);
  localparam int         RIDX  = $clog2(NUM_REGS);
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ECALL   = 3'd1;
  localparam logic [2:0] C_EBREAK  = 3'd2;
  localparam logic [2:0] C_ILLEGAL = 3'd3;
  localparam logic [2:0] C_MISFET  = 3'd4;
  localparam logic [2:0] C_MISMEM  = 3'd5;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t      r_state, w_next_state;
  logic        r_run;
  logic [31:0] r_pc, r_inst;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_retire, r_halt;
  logic [31:0] r_retire_pc, r_debug;
  logic [2:0]  r_cause;
  logic        r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [2:0]  r_mem_f3;
  logic [4:0]  r_mem_rd;

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_alu_b, w_alu;
  logic        w_alu_alt;
  logic [4:0]  w_shamt;
  logic        w_illegal_op, w_bad_reg, w_use_rd, w_use_rs1, w_use_rs2;
  logic        w_is_mem, w_is_store, w_ecall, w_ebreak, w_mis_mem, w_fault;
  logic [31:0] w_wb_val, w_target, w_mem_addr, w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [2:0]  w_cause;
  logic [31:0] w_ld_shift, w_ld_val;

  assign w_opcode = r_inst[6:0];
  assign w_rd     = r_inst[11:7];
  assign w_f3     = r_inst[14:12];
  assign w_rs1    = r_inst[19:15];
  assign w_rs2    = r_inst[24:20];
  assign w_f7     = r_inst[31:25];

  assign w_imm_i = {{20{r_inst[31]}}, r_inst[31:20]};
  assign w_imm_s = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
  assign w_imm_b = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
  assign w_imm_u = {r_inst[31:12], 12'd0};
  assign w_imm_j = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

  // Out-of-range indices read as zero here; they are flagged illegal before anything commits.
  assign w_rs1_val = (w_rs1 == 5'd0 || {1'b0, w_rs1} >= NREGS) ? 32'd0 : r_regs[w_rs1[RIDX-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0 || {1'b0, w_rs2} >= NREGS) ? 32'd0 : r_regs[w_rs2[RIDX-1:0]];

  always_comb begin
    w_alu_b   = (w_opcode == OP_OP) ? w_rs2_val : w_imm_i;
    w_alu_alt = w_f7[5] && ((w_opcode == OP_OP) || (w_f3 == 3'b101));
    w_shamt   = w_alu_b[4:0];
    case (w_f3)
      3'b000:  w_alu = w_alu_alt ? (w_rs1_val - w_alu_b) : (w_rs1_val + w_alu_b);
      3'b001:  w_alu = w_rs1_val << w_shamt;
      3'b010:  w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011:  w_alu = {31'd0, w_rs1_val < w_alu_b};
      3'b100:  w_alu = w_rs1_val ^ w_alu_b;
      3'b101:  w_alu = w_alu_alt ? 32'($signed(w_rs1_val) >>> w_shamt) : (w_rs1_val >> w_shamt);
      3'b110:  w_alu = w_rs1_val | w_alu_b;
      default: w_alu = w_rs1_val & w_alu_b;
    endcase
  end

  always_comb begin
    w_illegal_op = 1'b0;
    w_use_rd     = 1'b0;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    w_is_mem     = 1'b0;
    w_is_store   = 1'b0;
    w_ecall      = 1'b0;
    w_ebreak     = 1'b0;
    w_wb_val     = 32'd0;
    w_target     = r_pc + 32'd4;
    case (w_opcode)
      OP_LUI: begin
        w_use_rd = 1'b1;
        w_wb_val = w_imm_u;
      end
      OP_AUIPC: begin
        w_use_rd = 1'b1;
        w_wb_val = r_pc + w_imm_u;
      end
      OP_JAL: begin
        w_use_rd = 1'b1;
        w_wb_val = r_pc + 32'd4;
        w_target = r_pc + w_imm_j;
      end
      OP_JALR: begin
        w_use_rd     = 1'b1;
        w_use_rs1    = 1'b1;
        w_wb_val     = r_pc + 32'd4;
        w_target     = (w_rs1_val + w_imm_i) & ~32'd1;
        w_illegal_op = (w_f3 != 3'b000);
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        case (w_f3)
          3'b000:  if (w_rs1_val == w_rs2_val) w_target = r_pc + w_imm_b;
          3'b001:  if (w_rs1_val != w_rs2_val) w_target = r_pc + w_imm_b;
          3'b100:  if ($signed(w_rs1_val) <  $signed(w_rs2_val)) w_target = r_pc + w_imm_b;
          3'b101:  if ($signed(w_rs1_val) >= $signed(w_rs2_val)) w_target = r_pc + w_imm_b;
          3'b110:  if (w_rs1_val <  w_rs2_val) w_target = r_pc + w_imm_b;
          3'b111:  if (w_rs1_val >= w_rs2_val) w_target = r_pc + w_imm_b;
          default: w_illegal_op = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_use_rd     = 1'b1;
        w_use_rs1    = 1'b1;
        w_is_mem     = 1'b1;
        w_illegal_op = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_is_mem     = 1'b1;
        w_is_store   = 1'b1;
        w_illegal_op = (w_f3[2] || w_f3[1:0] == 2'b11);
      end
      OP_IMM: begin
        w_use_rd     = 1'b1;
        w_use_rs1    = 1'b1;
        w_wb_val     = w_alu;
        w_illegal_op = ((w_f3 == 3'b001) && (w_f7 != 7'd0)) ||
                       ((w_f3 == 3'b101) && (w_f7 != 7'd0) && (w_f7 != 7'b0100000));
      end
      OP_OP: begin
        w_use_rd     = 1'b1;
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_wb_val     = w_alu;
        w_illegal_op = !((w_f7 == 7'd0) ||
                         ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (r_inst == 32'h0000_0073)      w_ecall      = 1'b1;
        else if (r_inst == 32'h0010_0073) w_ebreak     = 1'b1;
        else                              w_illegal_op = 1'b1;
      end
      default: w_illegal_op = 1'b1;
    endcase
  end

  assign w_bad_reg = (w_use_rd  && {1'b0, w_rd}  >= NREGS) ||
                     (w_use_rs1 && {1'b0, w_rs1} >= NREGS) ||
                     (w_use_rs2 && {1'b0, w_rs2} >= NREGS);

  assign w_mem_addr = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
  assign w_mis_mem  = w_is_mem && (((w_f3[1:0] == 2'b01) && w_mem_addr[0]) ||
                                   ((w_f3[1:0] == 2'b10) && (w_mem_addr[1:0] != 2'b00)));

  always_comb begin
    w_cause = C_NONE;
    if (w_illegal_op || w_bad_reg)  w_cause = C_ILLEGAL;
    else if (w_ecall)               w_cause = C_ECALL;
    else if (w_ebreak)              w_cause = C_EBREAK;
    else if (w_target[1:0] != 2'b00) w_cause = C_MISFET;
    else if (w_mis_mem)             w_cause = C_MISMEM;
  end
  assign w_fault = (w_cause != C_NONE);

  always_comb begin
    case (w_f3[1:0])
      2'b00: begin
        w_st_wstrb = 4'b0001 << w_mem_addr[1:0];
        w_st_wdata = {4{w_rs2_val[7:0]}};
      end
      2'b01: begin
        w_st_wstrb = 4'b0011 << w_mem_addr[1:0];
        w_st_wdata = {2{w_rs2_val[15:0]}};
      end
      default: begin
        w_st_wstrb = 4'b1111;
        w_st_wdata = w_rs2_val;
      end
    endcase
  end

  assign w_ld_shift = i_dmem_rdata >> {r_mem_addr[1:0], 3'b000};
  always_comb begin
    case (r_mem_f3)
      3'b000:  w_ld_val = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b001:  w_ld_val = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b100:  w_ld_val = {24'd0, w_ld_shift[7:0]};
      3'b101:  w_ld_val = {16'd0, w_ld_shift[15:0]};
      default: w_ld_val = w_ld_shift;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (r_run && i_imem_ack) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_fault)       w_next_state = S_HALT;
        else if (w_is_mem) w_next_state = S_MEM;
        else               w_next_state = S_FETCH;
      end
      S_MEM:   if (i_dmem_ack) w_next_state = S_FETCH;
      default: w_next_state = S_HALT;
    endcase
  end

  // r_run holds the fetch request low until the first edge after reset releases.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_retire    <= 1'b0;
      r_retire_pc <= 32'd0;
      r_debug     <= 32'd0;
      r_halt      <= 1'b0;
      r_cause     <= C_NONE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_f3    <= 3'd0;
      r_mem_rd    <= 5'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
    end else begin
      r_run    <= 1'b1;
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: if (r_run && i_imem_ack) r_inst <= i_imem_rdata;
        S_EXEC: begin
          if (w_fault) begin
            r_halt  <= 1'b1;
            r_cause <= w_cause;
          end else if (w_is_mem) begin
            r_mem_we    <= w_is_store;
            r_mem_addr  <= w_mem_addr;
            r_mem_wstrb <= w_is_store ? w_st_wstrb : 4'd0;
            r_mem_wdata <= w_is_store ? w_st_wdata : 32'd0;
            r_mem_f3    <= w_f3;
            r_mem_rd    <= w_is_store ? 5'd0 : w_rd;
          end else begin
            if (w_use_rd && w_rd != 5'd0) r_regs[w_rd[RIDX-1:0]] <= w_wb_val;
            r_debug     <= (w_use_rd && w_rd != 5'd0) ? w_wb_val : 32'd0;
            r_retire    <= 1'b1;
            r_retire_pc <= r_pc;
            r_pc        <= w_target;
          end
        end
        S_MEM: begin
          if (i_dmem_ack) begin
            if (!r_mem_we && r_mem_rd != 5'd0) r_regs[r_mem_rd[RIDX-1:0]] <= w_ld_val;
            r_debug     <= (!r_mem_we && r_mem_rd != 5'd0) ? w_ld_val : 32'd0;
            r_retire    <= 1'b1;
            r_retire_pc <= r_pc;
            r_pc        <= r_pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_imem_req   = r_run && (r_state == S_FETCH);
  assign o_imem_addr  = r_run ? r_pc : 32'd0;
  assign o_dmem_req   = (r_state == S_MEM);
  assign o_dmem_we    = r_mem_we;
  assign o_dmem_addr  = {r_mem_addr[31:2], 2'b00};
  assign o_dmem_wstrb = r_mem_wstrb;
  assign o_dmem_wdata = r_mem_wdata;
  assign o_retire     = r_retire;
  assign o_retire_pc  = r_retire_pc;
  assign o_debug      = r_debug;
  assign o_halt       = r_halt;
  assign o_cause      = r_cause;
endmodule

// File: tb/tb_nano_riscv_mc.sv
// tb/tb_nano_riscv_mc.sv - scoreboard bench for nano_riscv_mc
// Directed programs; retire and data-port monitors pop expected records from queues.
module tb_nano_riscv_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        retire, halt;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, retire_pc, debug;
  logic [3:0]  dmem_wstrb;
  logic [2:0]  cause;

  nano_riscv_mc #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wstrb(dmem_wstrb),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_retire(retire), .o_retire_pc(retire_pc), .o_debug(debug), .o_halt(halt), .o_cause(cause)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;

  assign imem_ack   = imem_req && (icnt == idelay);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ack   = dmem_req && (dcnt == ddelay);
  assign dmem_rdata = dmem[dmem_addr[9:2]];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we)
      for (int b = 0; b < 4; b++)
        if (dmem_wstrb[b]) dmem[dmem_addr[9:2]][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
  end

  typedef struct { logic [31:0] pc; logic [31:0] dbg; } ret_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } mem_t;
  ret_t exp_ret[$];
  mem_t exp_mem[$];
  ret_t e_ret;
  mem_t e_mem;
  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ret(input logic [31:0] pc, input logic [31:0] dbg);
    exp_ret.push_back('{pc, dbg});
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    exp_mem.push_back('{we, a, s, d});
  endtask

  always @(negedge clk) begin
    if (!rst && retire) begin
      if (exp_ret.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire: pc=%0h debug=%0h", retire_pc, debug);
      end else begin
        e_ret = exp_ret.pop_front();
        check("retire_pc_debug", {retire_pc, debug}, {e_ret.pc, e_ret.dbg});
      end
    end
  end

  logic         dm_prev = 1'b0, dm_unstable = 1'b0;
  logic [68:0]  dm_first;
  always @(negedge clk) begin
    if (rst || !dmem_req) dm_prev = 1'b0;
    else begin
      if (!dm_prev) begin
        dm_first    = {dmem_we, dmem_addr, dmem_wstrb, dmem_wdata};
        dm_unstable = 1'b0;
      end else if ({dmem_we, dmem_addr, dmem_wstrb, dmem_wdata} !== dm_first)
        dm_unstable = 1'b1;
      dm_prev = 1'b1;
      if (dmem_ack) begin
        check("dmem_stable", dm_unstable, 1'b0);
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dmem: we=%0b addr=%0h", dmem_we, dmem_addr);
        end else begin
          e_mem = exp_mem.pop_front();
          check("dmem_req", {dmem_we, dmem_addr, dmem_wstrb, dmem_we ? dmem_wdata : 32'd0},
                {e_mem.we, e_mem.addr, e_mem.strb, e_mem.data});
        end
        dm_prev = 1'b0;
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  task automatic wait_halt(input logic [2:0] exp_cause, input int budget);
    int n = 0;
    while (!halt && n < budget) begin @(negedge clk); n++; end
    check("halt", halt, 1'b1);
    check("cause", cause, exp_cause);
    repeat (3) @(negedge clk);
    check("halt_quiet", {imem_req, dmem_req, retire, halt}, 4'b0001);
    check("scoreboard_drained", exp_ret.size() + exp_mem.size(), 0);
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    clear_imem();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
    clear_imem();
    ddelay = 3;
    imem[32'h100>>2] = 32'hFFB00093; push_ret(32'h100, 32'hFFFFFFFB);
    imem[32'h104>>2] = 32'h00103133; push_ret(32'h104, 32'h1);
    imem[32'h108>>2] = 32'h4010D193; push_ret(32'h108, 32'hFFFFFFFD);
    imem[32'h10C>>2] = 32'h00708013; push_ret(32'h10C, 32'h0);
    imem[32'h110>>2] = 32'hF01FF2EF; push_ret(32'h110, 32'h114);
    imem[32'h010>>2] = 32'h0000C463; push_ret(32'h010, 32'h0);
    imem[32'h018>>2] = 32'h0000E463; push_ret(32'h018, 32'h0);
    imem[32'h01C>>2] = 32'h11223337; push_ret(32'h01C, 32'h11223000);
    imem[32'h020>>2] = 32'h34430313; push_ret(32'h020, 32'h11223344);
    imem[32'h024>>2] = 32'h02602023; push_ret(32'h024, 32'h0);
    push_mem(1'b1, 32'h20, 4'hF, 32'h11223344);
    imem[32'h028>>2] = 32'h02100383; push_ret(32'h028, 32'h33);
    push_mem(1'b0, 32'h20, 4'h0, 32'h0);
    imem[32'h02C>>2] = 32'h021001A3; push_ret(32'h02C, 32'h0);
    push_mem(1'b1, 32'h20, 4'b1000, 32'hFBFBFBFB);
    imem[32'h030>>2] = 32'h02201403; push_ret(32'h030, 32'hFFFFFB22);
    push_mem(1'b0, 32'h20, 4'h0, 32'h0);
    imem[32'h034>>2] = 32'h02304483; push_ret(32'h034, 32'hFB);
    push_mem(1'b0, 32'h20, 4'h0, 32'h0);
    imem[32'h038>>2] = 32'h00001517; push_ret(32'h038, 32'h1038);
    imem[32'h03C>>2] = 32'h001285E7; push_ret(32'h03C, 32'h40);
    imem[32'h114>>2] = 32'h40130633; push_ret(32'h114, 32'h11223349);
    imem[32'h118>>2] = 32'h0000000F; push_ret(32'h118, 32'h0);
    imem[32'h11C>>2] = 32'h00000073;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wstrb, retire, halt, cause}, 128'd0);
    check("reset_data", {dmem_wdata, retire_pc, debug}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_fetch", {imem_req, imem_addr}, {1'b1, 32'h100});
    repeat (2) @(negedge clk);
    check("second_fetch", {imem_req, imem_addr}, {1'b1, 32'h104});
    wait_halt(3'd1, 400);
    check("dmem_word", dmem[8], 32'hFB223344);

    restart();
    idelay = 2; ddelay = 0;
    imem[32'h100>>2] = 32'h02200093; push_ret(32'h100, 32'h22);
    imem[32'h104>>2] = 32'h0000A103;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_halt(3'd5, 100);

    restart();
    idelay = 1; ddelay = 50;
    imem[32'h100>>2] = 32'h05500093; push_ret(32'h100, 32'h55);
    imem[32'h104>>2] = 32'h02102823;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int n = 0;
      while (!dmem_req && n < 100) begin @(negedge clk); n++; end
    end
    repeat (2) @(negedge clk);
    check("mem_req_before_reset", dmem_req, 1'b1);
    #2 rst = 1'b1;
    #1 check("reset_async_drop", {dmem_req, imem_req, retire, halt}, 4'b0000);
    clear_imem();
    imem[32'h100>>2] = 32'h00008113; push_ret(32'h100, 32'h0);
    imem[32'h104>>2] = 32'h00100073;
    repeat (2) @(negedge clk);
    check("store_dropped", dmem[12], 32'd0);
    rst = 1'b0;
    wait_halt(3'd2, 100);

    restart();
    idelay = 0; ddelay = 0;
    imem[32'h100>>2] = 32'h02208033;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_halt(3'd3, 50);

    restart();
    imem[32'h100>>2] = 32'h006000EF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_halt(3'd4, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
